scroll_counter_ctrl: RTL

Line/frame sequencer for a pair of cascaded 8-bit synchronous up/down counters forming a 16-bit scroll position counter. It generates the beam counters and blanking, and drives the counters' load_n, ent_n, enp_n, direction and P inputs. It also holds the CPU-written scroll/control registers and commits them at vblank. It sits between the CPU bus decode and the scroll counter pair in the video timing section.

---
 rtl/scroll_counter_ctrl_if.sv | 22 ++
 rtl/scroll_counter_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/scroll_counter_ctrl_if.sv
// scroll_counter_ctrl_if
// CPU-side register bus for the scroll counter controller.
//
// Handshake: cpu_wr is a single-clk write strobe qualified by cpu_addr and
// cpu_din. There is no back-pressure; every strobe is accepted, and cpu_ack
// pulses high for exactly one clk on the clk after the strobe, whatever cen
// is doing.
//
// Signals:
//   cpu_wr    write strobe (master -> slave)
//   cpu_addr  0 = scroll lo, 1 = scroll hi, 2 = control, 3 = unused
//   cpu_din   write data
//   cpu_ack   one-clk acknowledge (slave -> master)
interface scroll_counter_ctrl_if;
  logic       cpu_wr;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic       cpu_ack;

  modport master (output cpu_wr, output cpu_addr, output cpu_din, input cpu_ack);
  modport slave  (input cpu_wr, input cpu_addr, input cpu_din, output cpu_ack);
endinterface

// File: rtl/scroll_counter_ctrl.sv
// scroll_counter_ctrl
// Line/frame sequencer for a cascaded pair of 8-bit up/down counters that
// form the 16-bit scroll position. Generates beam counters and blanking,
// drives the counters' load/enable/direction/preset inputs, and holds the
// CPU scroll/control registers, committing them to the live copy at the
// start of vblank.
//
// Optional feature: define SCROLL_CTRL_FLIP_EN to make control bit2 (flip)
// invert the counting direction and the preset values.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   cen            pixel clock enable; its rising edge is one tick
//   cpu            register bus (slave modport)
//   cnt_q_lo       Q of the low counter, for the carry into the high one
//   hcnt, vcnt     beam position
//   hblank, vblank blanking flags
//   cnt_load_n     shared load_n, low in ST_LOAD and ST_INIT
//   cnt_enp_n      shared enp_n, low while active and not frozen
//   cnt_ent_lo_n   ent_n of the low counter
//   cnt_ent_hi_n   ent_n of the high counter (combinational carry)
//   cnt_dir        count direction, 1 = up
//   cnt_p_lo/hi    preset values
//   state          line FSM state, for observation
module scroll_counter_ctrl #(
  parameter int HTOTAL  = 384,
  parameter int HACTIVE = 256,
  parameter int VTOTAL  = 264,
  parameter int VACTIVE = 240
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  scroll_counter_ctrl_if.slave    cpu,
  input  logic [7:0]              cnt_q_lo,
  output logic [8:0]              hcnt,
  output logic [8:0]              vcnt,
  output logic                    hblank,
  output logic                    vblank,
  output logic                    cnt_load_n,
  output logic                    cnt_enp_n,
  output logic                    cnt_ent_lo_n,
  output logic                    cnt_ent_hi_n,
  output logic                    cnt_dir,
  output logic [7:0]              cnt_p_lo,
  output logic [7:0]              cnt_p_hi,
  output logic [1:0]              state
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HBL    = 2'd2;
  localparam logic [1:0] ST_LOAD   = 2'd3;

  localparam logic [8:0] H_LAST = 9'(HTOTAL - 1);
  localparam logic [8:0] H_ACT  = 9'(HACTIVE);
  localparam logic [8:0] V_LAST = 9'(VTOTAL - 1);
  localparam logic [8:0] V_ACT  = 9'(VACTIVE);

  logic       last_cen;
  logic       tick;
  logic       ack_r;
  logic [8:0] h_next;
  logic [8:0] v_next;
  logic [1:0] state_next;
  logic       commit;
  logic       freeze_next;
  logic       flip;
  logic       term_cnt;

  logic [7:0] shadow_lo, shadow_hi, live_lo, live_hi;
  logic [2:0] shadow_ctrl, live_ctrl;

  assign tick        = cen && !last_cen;
  assign cpu.cpu_ack = ack_r;

  always_comb begin
    h_next = (hcnt == H_LAST) ? 9'd0 : hcnt + 9'd1;
    v_next = vcnt;
    if (hcnt == H_LAST) v_next = (vcnt == V_LAST) ? 9'd0 : vcnt + 9'd1;
  end

  // Commit happens on the tick that lands on the first pixel of vblank.
  assign commit      = tick && (h_next == 9'd0) && (v_next == V_ACT);
  // Enable is registered on the same tick as the commit, so it must see
  // the freeze bit that is about to become live.
  assign freeze_next = commit ? shadow_ctrl[1] : live_ctrl[1];

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:   state_next = ST_ACTIVE;
      ST_ACTIVE: if (h_next == H_ACT)  state_next = ST_HBL;
      ST_HBL:    if (h_next == H_LAST) state_next = ST_LOAD;
      ST_LOAD:   if (h_next == 9'd0)   state_next = ST_ACTIVE;
      default:   state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_cen     <= 1'b0;
      ack_r        <= 1'b0;
      shadow_lo    <= 8'd0;
      shadow_hi    <= 8'd0;
      shadow_ctrl  <= 3'd0;
      live_lo      <= 8'd0;
      live_hi      <= 8'd0;
      live_ctrl    <= 3'd0;
      hcnt         <= 9'd0;
      vcnt         <= 9'd0;
      hblank       <= 1'b0;
      vblank       <= 1'b0;
      state        <= ST_INIT;
      cnt_load_n   <= 1'b0;
      cnt_enp_n    <= 1'b1;
      cnt_ent_lo_n <= 1'b1;
    end else begin
      last_cen <= cen;
      ack_r    <= cpu.cpu_wr;
      if (cpu.cpu_wr) begin
        case (cpu.cpu_addr)
          2'd0:    shadow_lo   <= cpu.cpu_din;
          2'd1:    shadow_hi   <= cpu.cpu_din;
          2'd2:    shadow_ctrl <= cpu.cpu_din[2:0];
          default: ;
        endcase
      end
      if (tick) begin
        hcnt         <= h_next;
        vcnt         <= v_next;
        hblank       <= (h_next >= H_ACT);
        vblank       <= (v_next >= V_ACT);
        state        <= state_next;
        cnt_load_n   <= (state_next != ST_LOAD);
        cnt_enp_n    <= !((state_next == ST_ACTIVE) && !freeze_next);
        cnt_ent_lo_n <= 1'b0;
        // Nonblocking: a write in this same clk lands in shadow after the
        // live copy has taken the old shadow value.
        if (commit) begin
          live_lo   <= shadow_lo;
          live_hi   <= shadow_hi;
          live_ctrl <= shadow_ctrl;
        end
      end
    end
  end

`ifdef SCROLL_CTRL_FLIP_EN
  assign flip = live_ctrl[2];
`else
  // Bit2 is kept in the register file but has no effect in this build.
  assign flip = live_ctrl[2] & 1'b0;
`endif

  assign cnt_dir  = live_ctrl[0] ^ flip;
  assign cnt_p_lo = live_lo ^ {8{flip}};
  assign cnt_p_hi = live_hi ^ {8{flip}};

  // Carry into the high counter; gated by the low counter's enable so it
  // stays inactive through reset until counting starts.
  assign term_cnt     = cnt_dir ? (cnt_q_lo == 8'hFF) : (cnt_q_lo == 8'h00);
  assign cnt_ent_hi_n = cnt_ent_lo_n | ~term_cnt;

endmodule
